// File: rtl/mem_loader.sv
// Streams DEPTH words into a RAM, checks a trailing checksum word and holds the CPU meanwhile.
// Define LOADER_READBACK_EN to add a VERIFY pass that re-reads the RAM and compares its sum.
`timescale 1ns/1ps
module mem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CSUM   = 3'd2,
`ifdef LOADER_READBACK_EN
    S_VERIFY = 3'd3,
`endif
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_sum;
  logic          r_err;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          w_ready;
  logic          w_xfer;
  logic          w_cnt_last;
  logic [DW-1:0] w_csum_tot;

  assign w_xfer     = in_valid & w_ready;
  assign w_cnt_last = (r_cnt == AW'(DEPTH - 1));
  assign w_csum_tot = r_sum + in_data;

`ifdef LOADER_READBACK_EN
  logic [DW-1:0] r_vsum;
  logic [DW-1:0] w_vsum_tot;
  logic          w_addr_last;
  assign w_vsum_tot  = r_vsum + mem_rdata;
  assign w_addr_last = (r_addr == AW'(DEPTH - 1));
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: if (w_xfer && w_cnt_last) w_next = S_CSUM;
`ifdef LOADER_READBACK_EN
      S_CSUM:   if (w_xfer) w_next = S_VERIFY;
      S_VERIFY: if (w_addr_last) w_next = S_DONE;
`else
      S_CSUM: if (w_xfer) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready  = (r_state == S_LOAD) || (r_state == S_CSUM);
    busy     = (r_state != S_IDLE);
    cpu_hold = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
  end

  // Write strobe, address and data are registered: the RAM sees a LOAD word one cycle after transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_sum   <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef LOADER_READBACK_EN
      r_vsum  <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            r_sum <= '0;
            r_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt;
            r_wdata <= in_data;
            r_sum   <= w_csum_tot;
            r_cnt   <= w_cnt_last ? '0 : r_cnt + AW'(1);
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            if (w_csum_tot != '0) r_err <= 1'b1;
`ifdef LOADER_READBACK_EN
            r_addr <= '0;
            r_vsum <= '0;
`endif
          end
        end
`ifdef LOADER_READBACK_EN
        S_VERIFY: begin
          r_vsum <= w_vsum_tot;
          if (w_addr_last) begin
            if (w_vsum_tot != r_sum) r_err <= 1'b1;
          end else begin
            r_addr <= r_addr + AW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: transaction-level model compared every cycle plus literal session checks.
`timescale 1ns/1ps
module tb_mem_loader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready, mem_we, cpu_hold, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  // RAM with optional corruption of word 3 on read
  logic [DW-1:0] ram [0:DEPTH-1];
  bit            corrupt = 1'b0;
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = (corrupt && mem_addr == AW'(3)) ? (ram[mem_addr] ^ 8'h5A) : ram[mem_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Session model: counts accepted words rather than tracking FSM states
  bit            m_act = 0, m_done = 0, m_err = 0, m_we = 0;
  int            m_n = 0, m_v = 0;
  logic [DW-1:0] m_sum = '0, m_wdata = '0, m_rs = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_mem [0:DEPTH-1];

  function automatic bit exp_ready();
    return m_act && (m_n <= DEPTH);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 0; m_done = 0; m_err = 0; m_we = 0; m_n = 0; m_v = 0;
      m_sum = '0; m_addr = '0; m_wdata = '0;
    end else begin
      m_we = 0;
      if (m_done) m_done = 0;
      else if (!m_act) begin
        if (start) begin m_act = 1; m_n = 0; m_v = 0; m_sum = '0; m_err = 0; end
      end else if (m_n < DEPTH) begin
        if (in_valid) begin
          m_we = 1; m_addr = AW'(m_n); m_wdata = in_data; m_mem[m_n] = in_data;
          m_sum = m_sum + in_data; m_n++;
        end
      end else if (m_n == DEPTH) begin
        if (in_valid) begin
          if (DW'(m_sum + in_data) != '0) m_err = 1;
          m_n++;
`ifdef LOADER_READBACK_EN
          m_v = 0; m_addr = '0;
`else
          m_act = 0; m_done = 1;
`endif
        end
      end else begin
        if (m_v == DEPTH - 1) begin
          m_rs = '0;
          for (int i = 0; i < DEPTH; i++)
            m_rs = m_rs + (m_mem[i] ^ ((corrupt && i == 3) ? 8'h5A : 8'h00));
          if (m_rs != m_sum) m_err = 1;
          m_act = 0; m_done = 1;
        end else begin
          m_v++; m_addr = AW'(m_v);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, exp_ready());
    chk("busy", busy, m_act || m_done);
    chk("cpu_hold", cpu_hold, m_act || m_done);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
  end

  int            n_done = 0, n_wr = 0, n_ver = 0;
  logic [AW-1:0] first_addr = '0;
  always @(negedge clk) begin
    if (done) n_done++;
    if (mem_we) begin
      if (n_wr == 0) first_addr = mem_addr;
      n_wr++;
    end
    if (busy && !in_ready && !done) n_ver++;
  end

  logic [DW-1:0] vec [0:DEPTH];

  task automatic fill(input logic [DW-1:0] base, input logic [DW-1:0] step, input logic [DW-1:0] bad);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vec[i] = base + step * DW'(i);
      s = s + vec[i];
    end
    vec[DEPTH] = DW'(0) - s + bad;
  endtask

  task automatic session(input bit gap, input bit poke, input int stop_after);
    int idx, cyc;
    bit acc;
    idx = 0; cyc = 0; n_done = 0; n_wr = 0; n_ver = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < DEPTH + 1 && !(stop_after > 0 && idx == stop_after)) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data  = vec[idx];
      start    = poke && (cyc == 4);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
      if (cyc > 200) begin
        n_chk++; n_err++;
        $display("FAIL stream_timeout: accepted %0d words, required %0d", idx, DEPTH + 1);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 60) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: no done pulse within %0d cycles", k);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Clean session, checksum 0x88
    fill(8'h00, 8'h01, 8'h00);
    chk("csum_literal", vec[DEPTH], 8'h88);
    session(0, 0, 0);
    wait_done();
    for (int i = 0; i < DEPTH; i++) chk("ram_s1", ram[i], i);
    chk("s1_writes", n_wr, 16);
    chk("s1_err", err, 0);
    chk("s1_done_cnt", n_done, 1);
    chk("s1_hold_after", cpu_hold, 0);
`ifdef LOADER_READBACK_EN
    chk("s1_verify_cycles", n_ver, DEPTH);
`else
    chk("s1_verify_cycles", n_ver, 0);
`endif

    // Bad checksum 0x89: all writes still occur, err sticky until next start
    fill(8'h00, 8'h01, 8'h01);
    chk("bad_csum_literal", vec[DEPTH], 8'h89);
    session(0, 0, 0);
    wait_done();
    chk("s2_writes", n_wr, 16);
    chk("s2_err", err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("s2_err_held", err, 1);

    // in_valid toggling with a start poke mid-session
    fill(8'h31, 8'h07, 8'h00);
    session(1, 1, 0);
    wait_done();
    for (int i = 0; i < DEPTH; i++) chk("ram_s3", ram[i], 8'h31 + 8'h07 * i);
    chk("s3_writes", n_wr, 16);
    chk("s3_err_cleared", err, 0);
    chk("s3_done_cnt", n_done, 1);

    // Reset after the fifth transfer
    fill(8'h40, 8'h01, 8'h00);
    session(0, 0, 5);
    reset = 1'b1;
    #1;
    chk("rr_ready", in_ready, 0);
    chk("rr_we", mem_we, 0);
    chk("rr_addr", mem_addr, 0);
    chk("rr_wdata", mem_wdata, 0);
    chk("rr_hold", cpu_hold, 0);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    session(0, 0, 0);
    wait_done();
    chk("rs_first_addr", first_addr, 0);
    chk("rs_writes", n_wr, 16);
    chk("rs_ram0", ram[0], 8'h40);
    chk("rs_ram15", ram[15], 8'h4F);

`ifdef LOADER_READBACK_EN
    // Read-back with word 3 corrupted
    corrupt = 1'b1;
    fill(8'h00, 8'h01, 8'h00);
    session(0, 0, 0);
    wait_done();
    chk("rb_err", err, 1);
    chk("rb_verify_cycles", n_ver, DEPTH);
    chk("rb_done_cnt", n_done, 1);
    corrupt = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of RAM words loaded per session.
REQ-002 The block SHALL have parameter AW, default 4, giving the address width (DEPTH <= 2**AW).
REQ-003 The block SHALL have parameter DW, default 8, giving the data word width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  requests a load session; sampled only in IDLE.
REQ-007 in_valid  input  1  in_data carries a valid word.
REQ-008 in_data  input  DW  program word, then checksum word.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 mem_we  output  1  RAM write strobe.
REQ-011 mem_addr  output  AW  RAM address for write or read-back.
REQ-012 mem_wdata  output  DW  RAM write data.
REQ-013 mem_rdata  input  DW  RAM combinational read data for mem_addr.
REQ-014 cpu_hold  output  1  holds the sequence counter and register loads of the processor.
REQ-015 busy  output  1  session in progress.
REQ-016 done  output  1  one-cycle pulse at session end.
REQ-017 err  output  1  sticky checksum or read-back error.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, CSUM, VERIFY, DONE.
REQ-019 IDLE -> LOAD on start=1; this also clears the word counter, running sum and err.
REQ-020 A word transfer SHALL occur exactly when in_valid=1 and in_ready=1 on a rising clk edge.
REQ-021 in_ready SHALL be 1 only in LOAD and CSUM; in_valid without in_ready is ignored and in_data needs no hold guarantees beyond the transfer cycle.
REQ-022 Each LOAD transfer SHALL register mem_we=1, mem_addr=word counter, mem_wdata=in_data for exactly the next cycle (1-cycle write latency), then increment the counter and add in_data to an 8-bit running sum (mod 2**DW).
REQ-023 After transfer number DEPTH (counter DEPTH-1), the FSM SHALL move to CSUM; the counter wraps to 0.
REQ-024 In CSUM, one transfer SHALL be accepted; err SHALL be set if (running sum + in_data) mod 2**DW != 0; no RAM write occurs.
REQ-025 CSUM SHALL go to VERIFY when built with read-back (see Configuration), otherwise to DONE.
REQ-026 VERIFY SHALL drive mem_addr 0..DEPTH-1, one per cycle, mem_we=0, summing mem_rdata; after address DEPTH-1 it SHALL set err if that sum differs from the LOAD sum, then go to DONE.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 busy and cpu_hold SHALL be 1 in every state except IDLE, and cpu_hold SHALL stay 1 during the DONE cycle.
REQ-029 start asserted outside IDLE SHALL be ignored; start held high in DONE SHALL not retrigger until IDLE.
REQ-030 mem_we SHALL never be 1 outside the cycle after a LOAD transfer.
REQ-031 err SHALL remain set until the next accepted start or reset.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, counter=0, sum=0, and every output to 0 (in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err), including mid-session; partially written RAM contents are not restored.

Configuration
REQ-033 With macro LOADER_READBACK_EN defined, the VERIFY state and read-back compare SHALL be compiled in; without it VERIFY SHALL not exist, CSUM SHALL go directly to DONE, and mem_addr SHALL change only on writes.

Verification
REQ-034 Start, stream 0x00..0x0F with in_valid=1 every cycle, checksum 0x88 -> 16 writes to addresses 0..15, err=0, done pulse once, cpu_hold low afterwards.
REQ-035 Same stream with checksum 0x89 -> all 16 writes occur, err=1 after CSUM and held until the next start.
REQ-036 in_valid toggling 1/0 each cycle during LOAD -> writes only on transfer cycles, addresses contiguous, no duplicate writes.
REQ-037 reset asserted after 5th transfer -> all outputs 0 immediately; new start restarts at address 0.
REQ-038 LOADER_READBACK_EN defined, RAM model corrupting word 3 -> VERIFY walks 16 addresses, err=1, done pulse after VERIFY.
REQ-039 start pulsed while busy -> no effect on counter, state or outputs.
